// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop-It game sequencer.
package stop_it_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SHOW = 3'd1,
    ST_RUN  = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_e;

  localparam int CountW   = 5;
  localparam int ScoreW   = 4;
  localparam int ScoreMax = 15;

endpackage

// File: rtl/stop_it_ctrl_tick_timer.sv
// Loadable down-counter of game ticks; done_o flags the tick that expires it.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load always wins, so a tick in the loading cycle is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i && !load_i && (cnt_q <= W'(1));

endmodule

// File: rtl/stop_it_ctrl.sv
// Stop-It game sequencer: target pick, display hold, running count, judging and streak score.
module stop_it_ctrl
  import stop_it_pkg::*;
#(
  parameter int SHOW_TICKS   = 4,
  parameter int RESULT_TICKS = 8,
  parameter int MAX_WRAPS    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CountW-1:0] rand_i,
  output logic              lfsr_next_o,
  output logic [2:0]        state_o,
  output logic [CountW-1:0] target_o,
  output logic [CountW-1:0] count_o,
  output logic [ScoreW-1:0] score_o,
  output logic              win_o,
  output logic              lose_o
);

  localparam int TimerMax = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
  localparam int TimerW   = $clog2(TimerMax) + 1;
  localparam int WrapW    = $clog2(MAX_WRAPS + 1);

  state_e              state_q, state_d;
  logic [CountW-1:0]   target_q, target_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [WrapW-1:0]    wrap_q, wrap_d;
  logic [ScoreW-1:0]   score_q, score_d;
  logic                timer_load;
  logic [TimerW-1:0]   timer_value;
  logic                timer_done;
  logic [ScoreW-1:0]   score_inc;

  tick_timer #(
    .W(TimerW)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (timer_load),
    .value_i(timer_value),
    .tick_i (tick_i),
    .done_o (timer_done)
  );

  assign score_inc = (score_q == ScoreW'(ScoreMax)) ? score_q : score_q + ScoreW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      count_q  <= '0;
      wrap_q   <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      score_q  <= score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    count_d     = count_q;
    wrap_d      = wrap_q;
    score_d     = score_q;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_SHOW;
          target_d    = rand_i;
          timer_load  = 1'b1;
          timer_value = TimerW'(SHOW_TICKS);
        end
      end
      ST_SHOW: begin
        if (timer_done) begin
          state_d = ST_RUN;
          count_d = '0;
          wrap_d  = '0;
        end
      end
      ST_RUN: begin
        // A stop is judged on the registered count, ahead of any same-cycle tick or timeout.
        if (stop_i) begin
          timer_load  = 1'b1;
          timer_value = TimerW'(RESULT_TICKS);
          if (count_q == target_q) begin
            state_d = ST_WIN;
            score_d = score_inc;
          end else begin
            state_d = ST_LOSE;
            score_d = '0;
          end
        end else if (tick_i) begin
          count_d = count_q + CountW'(1);
          if (count_q == '1) begin
            wrap_d = wrap_q + WrapW'(1);
            if (wrap_q == WrapW'(MAX_WRAPS - 1)) begin
              state_d     = ST_LOSE;
              score_d     = '0;
              timer_load  = 1'b1;
              timer_value = TimerW'(RESULT_TICKS);
            end
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    state_o     = state_q;
    target_o    = target_q;
    count_o     = count_q;
    score_o     = score_q;
    win_o       = (state_q == ST_WIN);
    lose_o      = (state_q == ST_LOSE);
    lfsr_next_o = (state_q == ST_IDLE) && !rst_i;
  end

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Directed self-checking bench for stop_it_ctrl with default parameters.
module tb_stop_it_ctrl;
  import stop_it_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] rnd = 5'd0;
  logic       lfsr_next;
  logic [2:0] state;
  logic [4:0] target;
  logic [4:0] count;
  logic [3:0] score;
  logic       win;
  logic       lose;

  int total = 0;
  int bad = 0;

  stop_it_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .start_i    (start),
    .stop_i     (stop),
    .rand_i     (rnd),
    .lfsr_next_o(lfsr_next),
    .state_o    (state),
    .target_o   (target),
    .count_o    (count),
    .score_o    (score),
    .win_o      (win),
    .lose_o     (lose)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle 1 ns past the edge before sampling.
  task automatic step(input logic t, input logic st, input logic sp);
    tick = t; start = st; stop = sp;
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Start a round with target r and advance the RUN count to k (no checks).
  task automatic go_run(input logic [4:0] r, input int k);
    rnd = r;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ticks(4);
    ticks(k);
  endtask

  task automatic finish_hold();
    step(1'b0, 1'b0, 1'b0);
    ticks(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, ST_IDLE); end
    total++; if (target !== 5'd0 || count !== 5'd0 || score !== 4'd0) begin bad++; $display("FAIL reset_data got t=%0d c=%0d s=%0d want 0/0/0", target, count, score); end
    total++; if (win !== 1'b0 || lose !== 1'b0) begin bad++; $display("FAIL reset_flags got w=%0b l=%0b want 0/0", win, lose); end
    total++; if (lfsr_next !== 1'b0) begin bad++; $display("FAIL reset_lfsr_in_rst got=%0b want=0", lfsr_next); end
    rst = 1'b0;
    #1;
    total++; if (lfsr_next !== 1'b1) begin bad++; $display("FAIL reset_lfsr_after got=%0b want=1", lfsr_next); end
    $display("test_reset done");
  endtask

  task automatic test_win();
    rnd = 5'd9;
    step(1'b0, 1'b1, 1'b0);
    total++; if (state !== ST_SHOW || target !== 5'd9) begin bad++; $display("FAIL win_show got st=%0d t=%0d want st=%0d t=9", state, target, ST_SHOW); end
    total++; if (lfsr_next !== 1'b0) begin bad++; $display("FAIL win_lfsr_show got=%0b want=0", lfsr_next); end
    step(1'b0, 1'b0, 1'b0);
    ticks(3);
    total++; if (state !== ST_SHOW) begin bad++; $display("FAIL win_show_3ticks got=%0d want=%0d", state, ST_SHOW); end
    ticks(1);
    total++; if (state !== ST_RUN || count !== 5'd0) begin bad++; $display("FAIL win_run_entry got st=%0d c=%0d want st=%0d c=0", state, count, ST_RUN); end
    ticks(9);
    total++; if (count !== 5'd9) begin bad++; $display("FAIL win_count9 got=%0d want=9", count); end
    step(1'b0, 1'b0, 1'b1);
    total++; if (state !== ST_WIN || win !== 1'b1 || lose !== 1'b0 || score !== 4'd1) begin bad++; $display("FAIL win_judge got st=%0d w=%0b l=%0b s=%0d want st=%0d w=1 l=0 s=1", state, win, lose, score, ST_WIN); end
    step(1'b0, 1'b0, 1'b0);
    ticks(7);
    total++; if (state !== ST_WIN) begin bad++; $display("FAIL win_hold7 got=%0d want=%0d", state, ST_WIN); end
    ticks(1);
    total++; if (state !== ST_IDLE || lfsr_next !== 1'b1 || win !== 1'b0) begin bad++; $display("FAIL win_idle got st=%0d n=%0b w=%0b want st=0 n=1 w=0", state, lfsr_next, win); end
    total++; if (target !== 5'd9 || count !== 5'd9) begin bad++; $display("FAIL win_idle_hold got t=%0d c=%0d want 9/9", target, count); end
    $display("test_win done");
  endtask

  task automatic test_miss();
    go_run(5'd3, 3); step(1'b0, 1'b0, 1'b1); finish_hold();
    go_run(5'd20, 20); step(1'b0, 1'b0, 1'b1); finish_hold();
    total++; if (score !== 4'd3) begin bad++; $display("FAIL miss_prior_score got=%0d want=3", score); end
    go_run(5'd9, 10);
    step(1'b0, 1'b0, 1'b1);
    total++; if (state !== ST_LOSE || lose !== 1'b1 || win !== 1'b0 || score !== 4'd0) begin bad++; $display("FAIL miss_judge got st=%0d l=%0b w=%0b s=%0d want st=%0d l=1 w=0 s=0", state, lose, win, score, ST_LOSE); end
    finish_hold();
    total++; if (state !== ST_IDLE) begin bad++; $display("FAIL miss_idle got=%0d want=0", state); end
    $display("test_miss done");
  endtask

  task automatic test_timeout();
    go_run(5'd4, 32);
    total++; if (state !== ST_RUN || count !== 5'd0) begin bad++; $display("FAIL timeout_wrap1 got st=%0d c=%0d want st=%0d c=0", state, count, ST_RUN); end
    ticks(31);
    total++; if (state !== ST_RUN || count !== 5'd31) begin bad++; $display("FAIL timeout_tick63 got st=%0d c=%0d want st=%0d c=31", state, count, ST_RUN); end
    ticks(1);
    total++; if (state !== ST_LOSE || count !== 5'd0 || lose !== 1'b1) begin bad++; $display("FAIL timeout_lose got st=%0d c=%0d l=%0b want st=%0d c=0 l=1", state, count, lose, ST_LOSE); end
    finish_hold();
    $display("test_timeout done");
  endtask

  task automatic test_same_cycle();
    go_run(5'd9, 9);
    step(1'b1, 1'b0, 1'b1);
    total++; if (state !== ST_WIN || count !== 5'd9 || score !== 4'd1) begin bad++; $display("FAIL same_cycle got st=%0d c=%0d s=%0d want st=%0d c=9 s=1", state, count, score, ST_WIN); end
    finish_hold();
    $display("test_same_cycle done");
  endtask

  task automatic test_saturation();
    logic [3:0] exp_score;
    exp_score = score;
    for (int i = 0; i < 16; i++) begin
      go_run(5'(i + 2), i + 2);
      step(1'b0, 1'b0, 1'b1);
      exp_score = (exp_score == 4'd15) ? 4'd15 : exp_score + 4'd1;
      total++; if (score !== exp_score) begin bad++; $display("FAIL sat_round%0d got=%0d want=%0d", i, score, exp_score); end
      finish_hold();
    end
    total++; if (score !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", score); end
    $display("test_saturation done score=%0d", score);
  endtask

  task automatic test_ignored();
    step(1'b0, 1'b0, 1'b1);
    total++; if (state !== ST_IDLE || score !== 4'd15) begin bad++; $display("FAIL ign_stop_idle got st=%0d s=%0d want st=0 s=15", state, score); end
    rnd = 5'd6;
    step(1'b0, 1'b1, 1'b1);
    total++; if (state !== ST_SHOW || target !== 5'd6) begin bad++; $display("FAIL ign_start_stop got st=%0d t=%0d want st=%0d t=6", state, target, ST_SHOW); end
    rnd = 5'd25;
    step(1'b0, 1'b1, 1'b1);
    total++; if (state !== ST_SHOW || target !== 5'd6) begin bad++; $display("FAIL ign_show got st=%0d t=%0d want st=%0d t=6", state, target, ST_SHOW); end
    ticks(4);
    ticks(6);
    step(1'b0, 1'b0, 1'b1);
    total++; if (state !== ST_WIN) begin bad++; $display("FAIL ign_win_entry got=%0d want=%0d", state, ST_WIN); end
    step(1'b0, 1'b1, 1'b0);
    total++; if (state !== ST_WIN || target !== 5'd6) begin bad++; $display("FAIL ign_start_win got st=%0d t=%0d want st=%0d t=6", state, target, ST_WIN); end
    ticks(8);
    $display("test_ignored done");
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1; step(1'b0, 1'b0, 1'b0); rst = 1'b0;
    go_run(5'd1, 1); step(1'b0, 1'b0, 1'b1); finish_hold();
    go_run(5'd2, 2); step(1'b0, 1'b0, 1'b1); finish_hold();
    go_run(5'd20, 17);
    total++; if (state !== ST_RUN || count !== 5'd17 || score !== 4'd2) begin bad++; $display("FAIL rmid_setup got st=%0d c=%0d s=%0d want st=%0d c=17 s=2", state, count, score, ST_RUN); end
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    total++; if (state !== ST_IDLE || count !== 5'd0 || target !== 5'd0 || score !== 4'd0) begin bad++; $display("FAIL rmid_clear got st=%0d c=%0d t=%0d s=%0d want all 0", state, count, target, score); end
    total++; if (win !== 1'b0 || lose !== 1'b0 || lfsr_next !== 1'b0) begin bad++; $display("FAIL rmid_flags got w=%0b l=%0b n=%0b want 0/0/0", win, lose, lfsr_next); end
    rst = 1'b0;
    #1;
    total++; if (lfsr_next !== 1'b1) begin bad++; $display("FAIL rmid_lfsr_after got=%0b want=1", lfsr_next); end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    test_reset();
    test_win();
    test_miss();
    test_timeout();
    test_same_cycle();
    test_saturation();
    test_ignored();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stop_it_ctrl.md
# stop_it_ctrl

- Game sequencer for the Stop-It game; owns the 5-bit `lfsr` instance's `next_i` and consumes its `rand_o`.
- Per round: latches a random target, shows it, then runs a visible 5-bit counter the player must stop on the target value.
- Judges the stop as win or lose, keeps a streak score and returns to idle.
- Sits between the button/tick front end and the display driver.

## Interface
- `SHOW_TICKS`, default 4: tick pulses the target stays displayed before counting starts.
- `RESULT_TICKS`, default 8: tick pulses a WIN/LOSE result is held.
- `MAX_WRAPS`, default 2: count wraps (31→0) in RUN before an automatic LOSE.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `tick_i` in 1: one-cycle game-speed enable pulse.
- `start_i` in 1: one-cycle start pulse (debounced upstream).
- `stop_i` in 1: one-cycle stop pulse (debounced upstream).
- `rand_i` in 5: random value from lfsr `rand_o`.
- `lfsr_next_o` out 1: drives lfsr `next_i`.
- `state_o` out 3: current `state_e` encoding.
- `target_o` out 5: latched target.
- `count_o` out 5: running count.
- `score_o` out 4: consecutive-win streak.
- `win_o` out 1: high while in WIN.
- `lose_o` out 1: high while in LOSE.

## Operation
- States: IDLE, SHOW, RUN, WIN, LOSE.
- IDLE:
  - `lfsr_next_o` = 1 every cycle; the player's timing stirs entropy.
  - `start_i` → SHOW; `target_o` ← `rand_i` sampled that same cycle, before the lfsr advance takes effect.
  - `stop_i` ignored; `start_i` + `stop_i` together: start wins.
- SHOW:
  - Tick timer loaded with SHOW_TICKS on entry; decrements on `tick_i`.
  - At expiry → RUN with `count_o` = 0 and wrap counter = 0.
  - `start_i` and `stop_i` ignored.
- RUN:
  - `count_o` += 1 on each `tick_i`, wrapping 31→0; each 31→0 wrap increments the wrap counter.
  - `stop_i`: compare registered `count_o` (pre-increment if `tick_i` is in the same cycle) with `target_o`. Equal → WIN, else LOSE.
  - Timeout: the tick that performs the MAX_WRAPS-th wrap with no stop → LOSE. `stop_i` on that same cycle takes priority and is judged.
  - `count_o` freezes on exit.
- WIN:
  - On entry `score_o` += 1, saturating at 15.
  - Timer loaded with RESULT_TICKS; at expiry → IDLE.
- LOSE:
  - On entry `score_o` ← 0.
  - Same hold as WIN, then → IDLE.
- `lfsr_next_o` = 0 outside IDLE and while `rst_i` = 1.
- `target_o` and `count_o` hold their values through IDLE until the next start.

## Timing
- Reset (cycle after `rst_i` sampled high): state IDLE; `target_o`, `count_o`, `score_o` = 0; `win_o`, `lose_o` = 0.
- `lfsr_next_o` is 0 while `rst_i` is high and 1 from the first non-reset IDLE cycle.
- `rst_i` in any state, mid-round included, aborts the round; score is cleared.
- `start_i` at cycle N → `state_o` = SHOW at N+1; `target_o` valid at N+1.
- SHOW lasts until the SHOW_TICKS-th `tick_i` after entry; RUN begins the following cycle.
- `stop_i` at cycle N in RUN → WIN/LOSE at N+1; `win_o`/`lose_o` and updated `score_o` visible at N+1.
- A tick coincident with state entry does not count toward that state's timer. Timers count ticks from the cycle after entry.
- `state_o`, `win_o`, `lose_o` and all data outputs are registered or decoded from registered state; `lfsr_next_o` is combinational from state and `rst_i` only.

## Structure
- `stop_it_pkg`:
  - `state_e` enum (3-bit logic).
  - `CountW` = 5, `ScoreW` = 4, `ScoreMax` = 15.
- Sub-module `tick_timer`:
  - Parameterised loadable down-counter, width `$clog2(max(SHOW_TICKS, RESULT_TICKS))+1`.
  - Inputs `load_i`, `value_i`, `tick_i`; output `done_o`.
  - Shared by SHOW, WIN and LOSE.
- `stop_it_ctrl` holds the FSM, count, wrap counter, target and score registers.

## Test plan
- Win path: defaults, `rand_i` = 9, pulse `start_i` → `target_o` = 9; after 4 ticks RUN; `stop_i` when `count_o` = 9 → WIN next cycle, `score_o` = 1; after 8 ticks IDLE with `lfsr_next_o` = 1.
- Miss: target 9, `stop_i` at `count_o` = 10 → LOSE, `score_o` = 0 (from 3 prior wins).
- Timeout: no stop, `rand_i` = 4 → LOSE on the 64th RUN tick (second 31→0 wrap); `count_o` = 0.
- Same-cycle stop and tick: `count_o` = 9 = target, `stop_i` + `tick_i` together → WIN; `count_o` stays 9.
- Saturation and ignored inputs: 16 consecutive wins → `score_o` = 15. `start_i` during SHOW/WIN and `stop_i` during SHOW/IDLE have no effect.
- Reset mid-RUN: `rst_i` high for 1 cycle at `count_o` = 17, `score_o` = 2 → next cycle IDLE, all outputs 0. `lfsr_next_o` = 0 during reset and 1 afterward.
